// File: rtl/never_match_iter.sv
// Walks per-nibble match masks, one match beat per cycle,
// closing each search with a match-count terminator beat.
module never_match_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH/4-1:0]    in_mask,
  input  logic                  in_zero,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      out_idx,
  output logic                  out_end
);

  localparam int NN    = WIDTH / 4;
  localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
  localparam int WC_W  = CNT_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    TERM
  } state_t;

  state_t            r_state, w_state;
  logic [NN-1:0]     r_pending, w_pending;
  logic              r_last, w_last;
  logic [WC_W-1:0]   r_word_cnt, w_word_cnt;
  logic [CNT_W-1:0]  r_match_cnt, w_match_cnt;
  logic [IDX_W-1:0]  w_p;
  logic [NN-1:0]     w_pend_clr;
  logic [CNT_W-1:0]  w_match_inc;

  // Priority pick of the lowest pending nibble.
  always_comb begin
    w_p = '0;
    for (int i = NN - 1; i >= 0; i--) begin
      if (r_pending[i]) w_p = i[IDX_W-1:0];
    end
  end

  assign w_pend_clr  = r_pending & (r_pending - 1'b1);
  assign w_match_inc = (&r_match_cnt) ? r_match_cnt
                                      : r_match_cnt + 1'b1;

  always_comb begin
    w_state     = r_state;
    w_pending   = r_pending;
    w_last      = r_last;
    w_word_cnt  = r_word_cnt;
    w_match_cnt = r_match_cnt;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (!in_zero) begin
            w_pending = in_mask;
            w_last    = in_last;
            w_state   = SCAN;
          end else if (!in_last) begin
            w_word_cnt = r_word_cnt + 1'b1;
          end else begin
            w_state = TERM;
          end
        end
      end
      SCAN: begin
        if (out_ready) begin
          w_pending   = w_pend_clr;
          w_match_cnt = w_match_inc;
          if (w_pend_clr == '0) begin
            if (r_last) begin
              w_state = TERM;
            end else begin
              w_state    = IDLE;
              w_word_cnt = r_word_cnt + 1'b1;
            end
          end
        end
      end
      TERM: begin
        if (out_ready) begin
          w_word_cnt  = '0;
          w_match_cnt = '0;
          w_state     = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_last      <= 1'b0;
      r_word_cnt  <= '0;
      r_match_cnt <= '0;
    end else begin
      r_state     <= w_state;
      r_pending   <= w_pending;
      r_last      <= w_last;
      r_word_cnt  <= w_word_cnt;
      r_match_cnt <= w_match_cnt;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state != IDLE);
  assign out_end   = (r_state == TERM);

  always_comb begin
    out_idx = '0;
    unique case (r_state)
      SCAN:    out_idx = {r_word_cnt, w_p};
      TERM:    out_idx = r_match_cnt;
      default: out_idx = '0;
    endcase
  end

endmodule

// File: tb/tb_never_match_iter.sv
// Directed bench for never_match_iter (WIDTH=32, CNT_W=16).
// Inputs change and outputs are sampled on the falling edge.
module tb_never_match_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_mask;
  logic        in_zero;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_idx;
  logic        out_end;

  int n_tests = 0;
  int n_fail  = 0;

  never_match_iter #(.WIDTH(32), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .in_zero   (in_zero),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_end   (out_end)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] m, input logic last);
    in_valid = 1'b1;
    in_mask  = m;
    in_zero  = (m == 8'h00);
    in_last  = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_mask  = 8'h00;
    in_zero  = 1'b1;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_in();
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, out_end, out_idx} !== {3'b100, 16'd0}) begin
      n_fail++;
      $display("FAIL reset got rdy/v/e/idx=%b%b%b/%0d exp 100/0",
               in_ready, out_valid, out_end, out_idx);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [16:0] exp [4];
    exp[0] = {1'b0, 16'd0};
    exp[1] = {1'b0, 16'd2};
    exp[2] = {1'b0, 16'd7};
    exp[3] = {1'b1, 16'd3};
    drive(8'h85, 1'b1);
    @(negedge clk);
    idle_in();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({in_ready, out_valid, out_end, out_idx} !== {2'b01, exp[k]}) begin
        n_fail++;
        $display("FAIL single_beat%0d got r/v=%b%b end=%b idx=%0d exp 01 %b %0d",
                 k, in_ready, out_valid, out_end, out_idx, exp[k][16], exp[k][15:0]);
      end
      @(negedge clk);
    end
    n_tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_idle got r/v=%b%b exp 10", in_ready, out_valid);
    end
  endtask

  task automatic test_multi();
    drive(8'h00, 1'b0);
    @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL multi_zero_absorb got r/v=%b%b exp 10", in_ready, out_valid);
    end
    drive(8'h10, 1'b0);
    @(negedge clk);
    idle_in();
    n_tests++;
    if ({out_valid, out_end, out_idx} !== {2'b10, 16'd12}) begin
      n_fail++;
      $display("FAIL multi_idx12 got v/e=%b%b idx=%0d exp 10 12",
               out_valid, out_end, out_idx);
    end
    @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL multi_bubble got r/v=%b%b exp 10", in_ready, out_valid);
    end
    drive(8'h01, 1'b1);
    @(negedge clk);
    idle_in();
    n_tests++;
    if ({out_valid, out_end, out_idx} !== {2'b10, 16'd16}) begin
      n_fail++;
      $display("FAIL multi_idx16 got v/e=%b%b idx=%0d exp 10 16",
               out_valid, out_end, out_idx);
    end
    @(negedge clk);
    n_tests++;
    if ({out_valid, out_end, out_idx} !== {2'b11, 16'd2}) begin
      n_fail++;
      $display("FAIL multi_term got v/e=%b%b idx=%0d exp 11 2",
               out_valid, out_end, out_idx);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    drive(8'h06, 1'b1);
    @(negedge clk);
    idle_in();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if ({in_ready, out_valid, out_end, out_idx} !== {3'b010, 16'd1}) begin
        n_fail++;
        $display("FAIL bp_hold%0d got r/v/e=%b%b%b idx=%0d exp 010 1",
                 k, in_ready, out_valid, out_end, out_idx);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({out_valid, out_end, out_idx} !== {2'b10, 16'd2}) begin
      n_fail++;
      $display("FAIL bp_idx2 got v/e=%b%b idx=%0d exp 10 2",
               out_valid, out_end, out_idx);
    end
    @(negedge clk);
    n_tests++;
    if ({out_valid, out_end, out_idx} !== {2'b11, 16'd2}) begin
      n_fail++;
      $display("FAIL bp_term got v/e=%b%b idx=%0d exp 11 2",
               out_valid, out_end, out_idx);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_final();
    drive(8'h00, 1'b1);
    @(negedge clk);
    idle_in();
    n_tests++;
    if ({in_ready, out_valid, out_end, out_idx} !== {3'b011, 16'd0}) begin
      n_fail++;
      $display("FAIL zero_term got r/v/e=%b%b%b idx=%0d exp 011 0",
               in_ready, out_valid, out_end, out_idx);
    end
    @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_idle got r/v=%b%b exp 10", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive(8'h00, 1'b0);
    @(negedge clk);
    drive(8'h03, 1'b1);
    @(negedge clk);
    idle_in();
    out_ready = 1'b0;
    n_tests++;
    if ({out_valid, out_idx} !== {1'b1, 16'd8}) begin
      n_fail++;
      $display("FAIL rmid_scan got v=%b idx=%0d exp 1 8", out_valid, out_idx);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rmid_async got r/v=%b%b exp 10", in_ready, out_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    drive(8'h80, 1'b1);
    @(negedge clk);
    idle_in();
    n_tests++;
    if ({out_valid, out_end, out_idx} !== {2'b10, 16'd7}) begin
      n_fail++;
      $display("FAIL rmid_idx7 got v/e=%b%b idx=%0d exp 10 7",
               out_valid, out_end, out_idx);
    end
    @(negedge clk);
    n_tests++;
    if ({out_valid, out_end, out_idx} !== {2'b11, 16'd1}) begin
      n_fail++;
      $display("FAIL rmid_term got v/e=%b%b idx=%0d exp 11 1",
               out_valid, out_end, out_idx);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive(8'h00, 1'b0);
    @(negedge clk);
    drive(8'h01, 1'b1);
    @(negedge clk);
    idle_in();
    n_tests++;
    if ({out_valid, out_end, out_idx} !== {2'b10, 16'd8}) begin
      n_fail++;
      $display("FAIL b2b_idx8 got v/e=%b%b idx=%0d exp 10 8",
               out_valid, out_end, out_idx);
    end
    @(negedge clk);
    drive(8'h02, 1'b1);
    out_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, out_end, out_idx} !== {3'b011, 16'd1}) begin
      n_fail++;
      $display("FAIL b2b_term_hold got r/v/e=%b%b%b idx=%0d exp 011 1",
               in_ready, out_valid, out_end, out_idx);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_idle got r/v=%b%b exp 10", in_ready, out_valid);
    end
    @(negedge clk);
    idle_in();
    n_tests++;
    if ({out_valid, out_end, out_idx} !== {2'b10, 16'd1}) begin
      n_fail++;
      $display("FAIL b2b_idx1 got v/e=%b%b idx=%0d exp 10 1",
               out_valid, out_end, out_idx);
    end
    @(negedge clk);
    n_tests++;
    if ({out_valid, out_end, out_idx} !== {2'b11, 16'd1}) begin
      n_fail++;
      $display("FAIL b2b_term got v/e=%b%b idx=%0d exp 11 1",
               out_valid, out_end, out_idx);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_zero_final();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
